// File: rtl/arbiter_pkg.sv
// Shared types for the multi-port memory arbiter: FSM state and latched operation.
package arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } arb_op_e;

  // A port asking for both read and write at once is treated as not asking at all.
  function automatic arb_op_e decode_op(input logic rd, input logic wr);
    case ({rd, wr})
      2'b10:   return OP_READ;
      2'b01:   return OP_WRITE;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rr_select.sv
// Rotating-priority winner select: search starts at ptr and wraps; ptr tied to 0 gives
// plain lowest-index-wins priority.
module rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] j;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    j         = '0;
    for (int i = 0; i < N; i++) begin
      j = IDX_W'((int'(ptr) + i) % N);
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt[j]    = 1'b1;
        gnt_idx   = j;
      end
    end
  end

endmodule

// File: rtl/multi_port_arbiter.sv
// Arbitrates NUM_PORTS cache ports onto one physical memory port, one transaction at a time.
// Define MULTI_PORT_ARBITER_RR_EN for round-robin selection; otherwise lowest index wins.
module multi_port_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] port_address,
  input  logic [NUM_PORTS-1:0][LINE_W-1:0] port_wdata,
  input  logic [NUM_PORTS-1:0]             port_read,
  input  logic [NUM_PORTS-1:0]             port_write,
  output logic [LINE_W-1:0]                port_rdata,
  output logic [NUM_PORTS-1:0]             port_resp,
  output logic [ADDR_W-1:0]                pmem_address,
  output logic [LINE_W-1:0]                pmem_wdata,
  output logic                             pmem_read,
  output logic                             pmem_write,
  input  logic                             pmem_resp,
  input  logic [LINE_W-1:0]                pmem_rdata,
  output logic                             busy,
  output logic [IDX_W-1:0]                 grant_idx
);

  // Handshake: a port requests by holding exactly one of read/write until its port_resp
  // pulse; the memory sees pmem_read/pmem_write held until it answers with pmem_resp.
  arb_state_e            state_q, state_d;
  arb_op_e               op_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [IDX_W-1:0]      gidx_q;
  logic [NUM_PORTS-1:0]  gnt_q;
  logic [NUM_PORTS-1:0]  req, sel_gnt;
  logic [IDX_W-1:0]      sel_idx, ptr;
  logic                  sel_valid, load, done;

  assign req = port_read ^ port_write;

  rr_select #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_select (
    .req       (req),
    .ptr       (ptr),
    .gnt       (sel_gnt),
    .gnt_idx   (sel_idx),
    .gnt_valid (sel_valid)
  );

`ifdef MULTI_PORT_ARBITER_RR_EN
  logic [IDX_W-1:0] ptr_q;

  // Next search begins just past the port that completed, so it yields to any other requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (done) begin
      ptr_q <= (gidx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gidx_q + 1'b1;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    done      = 1'b0;
    port_resp = '0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (pmem_resp) begin
          done      = 1'b1;
          port_resp = gnt_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        op_q    <= decode_op(port_read[sel_idx], port_write[sel_idx]);
        addr_q  <= port_address[sel_idx];
        wdata_q <= port_wdata[sel_idx];
        gidx_q  <= sel_idx;
        gnt_q   <= sel_gnt;
      end
    end
  end

  // Memory side is driven only from the latched copy; port inputs are ignored while BUSY.
  assign busy         = (state_q == BUSY);
  assign pmem_read    = busy && (op_q == OP_READ);
  assign pmem_write   = busy && (op_q == OP_WRITE);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign grant_idx    = gidx_q;
  assign port_rdata   = pmem_rdata;

endmodule

// File: tb/tb_multi_port_arbiter.sv
// Scoreboard bench for multi_port_arbiter: directed cases, then randomized traffic checked
// against a reference model of the arbitration rules (honours MULTI_PORT_ARBITER_RR_EN).
module tb_multi_port_arbiter;

  localparam int NP   = 3;
  localparam int AW   = 32;
  localparam int LW   = 256;
  localparam int IW   = $clog2(NP);
  localparam int RQ_W = 8 + 2 + AW + LW;
  localparam int RS_W = NP + LW;

  logic                    clk;
  logic                    rst_n;
  logic [NP-1:0][AW-1:0]   port_address;
  logic [NP-1:0][LW-1:0]   port_wdata;
  logic [NP-1:0]           port_read;
  logic [NP-1:0]           port_write;
  logic [LW-1:0]           port_rdata;
  logic [NP-1:0]           port_resp;
  logic [AW-1:0]           pmem_address;
  logic [LW-1:0]           pmem_wdata;
  logic                    pmem_read;
  logic                    pmem_write;
  logic                    pmem_resp;
  logic [LW-1:0]           pmem_rdata;
  logic                    busy;
  logic [IW-1:0]           grant_idx;

  multi_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port_address (port_address),
    .port_wdata   (port_wdata),
    .port_read    (port_read),
    .port_write   (port_write),
    .port_rdata   (port_rdata),
    .port_resp    (port_resp),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .busy         (busy),
    .grant_idx    (grant_idx)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [RQ_W-1:0] exp_req_q[$];
  logic [RS_W-1:0] exp_rsp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int rr_start = 0;
  int cur_winner = -1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int w = 0; w < LW / 32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  // Reference model: pick the winner among ports with exactly one strobe set.
  function automatic int pick_winner(input logic [NP-1:0] reqs);
    int best, bestd, d;
    best  = -1;
    bestd = NP;
    for (int i = 0; i < NP; i++) begin
      if (reqs[i]) begin
`ifdef MULTI_PORT_ARBITER_RR_EN
        d = (i - rr_start + NP) % NP;
`else
        d = i;
`endif
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_req(input logic [NP-1:0] rd, input logic [NP-1:0] wr, input logic [AW-1:0] base);
    logic [NP-1:0] reqs;
    port_read  = rd;
    port_write = wr;
    for (int i = 0; i < NP; i++) begin
      port_address[i] = base + AW'(i * 32'h1000);
      port_wdata[i]   = rand_line();
    end
    reqs = rd ^ wr;
    cur_winner = -1;
    if (reqs != '0) begin
      cur_winner = pick_winner(reqs);
      rr_start   = (cur_winner + 1) % NP;
      exp_req_q.push_back({8'(cur_winner), wr[cur_winner], rd[cur_winner],
                           port_address[cur_winner], port_wdata[cur_winner]});
    end
  endtask

  task automatic gen_set(output logic [NP-1:0] rd, output logic [NP-1:0] wr);
    int p;
    rd = NP'($urandom());
    wr = NP'($urandom());
    p  = $urandom_range(0, NP - 1);
    if ($urandom_range(0, 1) == 1) begin
      rd[p] = 1'b1;
      wr[p] = 1'b0;
    end else begin
      rd[p] = 1'b0;
      wr[p] = 1'b1;
    end
  endtask

  task automatic perturb();
    for (int i = 0; i < NP; i++) port_address[i] = $urandom();
    port_read  = NP'($urandom());
    port_write = NP'($urandom());
    pmem_rdata = rand_line();
  endtask

  // Called in an IDLE cycle with a request already applied; serves it and applies the next set.
  task automatic run_txn(input int delay, input logic [LW-1:0] rdata,
                         input logic [NP-1:0] nrd, input logic [NP-1:0] nwr, input logic [AW-1:0] nbase);
    logic [NP-1:0] oh;
    check("idle_before_grant", LW'(busy), LW'(1'b0));
    @(posedge clk); #1;
    check("grant_latency", LW'(busy), LW'(1'b1));
    repeat (delay) begin
      perturb();
      @(posedge clk); #1;
    end
    oh = '0;
    if (cur_winner >= 0) oh[cur_winner] = 1'b1;
    pmem_rdata = rdata;
    pmem_resp  = 1'b1;
    exp_rsp_q.push_back({oh, rdata});
    apply_req(nrd, nwr, nbase);
    @(posedge clk); #1;
    pmem_resp  = 1'b0;
    pmem_rdata = rand_line();
  endtask

  // ---------------- monitor ----------------
  logic            prev_busy = 1'b0;
  logic [RQ_W-1:0] cur_req   = '0;
  logic [RS_W-1:0] rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      check("port_rdata", port_rdata, pmem_rdata);
      if (busy && !prev_busy) begin
        if (exp_req_q.size() == 0) begin
          check("unexpected_grant", LW'(grant_idx), LW'(8'hff));
        end else begin
          cur_req = exp_req_q.pop_front();
        end
      end
      if (busy) begin
        check("grant_idx", LW'(grant_idx), LW'(cur_req[RQ_W-1 -: 8]));
        check("pmem_read", LW'(pmem_read), LW'(cur_req[AW+LW]));
        check("pmem_write", LW'(pmem_write), LW'(cur_req[AW+LW+1]));
        check("pmem_address", LW'(pmem_address), LW'(cur_req[LW +: AW]));
        check("pmem_wdata", pmem_wdata, cur_req[LW-1:0]);
      end else begin
        check("idle_port_resp", LW'(port_resp), '0);
        check("idle_pmem_op", LW'({pmem_read, pmem_write}), '0);
      end
      if (port_resp != '0) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_resp", LW'(port_resp), '0);
        end else begin
          rsp = exp_rsp_q.pop_front();
          check("port_resp", LW'(port_resp), LW'(rsp[RS_W-1 -: NP]));
          check("resp_rdata", port_rdata, rsp[LW-1:0]);
        end
      end
      prev_busy = busy;
    end
  end

  // ---------------- stimulus ----------------
  logic [NP-1:0] rd, wr, nrd, nwr;

  initial begin
    rst_n        = 1'b0;
    port_address = '0;
    port_wdata   = '0;
    port_read    = '0;
    port_write   = '0;
    pmem_resp    = 1'b0;
    pmem_rdata   = rand_line();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", LW'(busy), '0);
    check("rst_port_resp", LW'(port_resp), '0);
    check("rst_pmem_op", LW'({pmem_read, pmem_write}), '0);
    check("rst_pmem_address", LW'(pmem_address), '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_grant_idx", LW'(grant_idx), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stray response while idle
    pmem_resp = 1'b1;
    #1;
    check("stray_port_resp", LW'(port_resp), '0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    check("stray_stays_idle", LW'(busy), '0);

    // Single read from port1 at 0x1040, answered after 3 cycles with 0xA5 pattern
    apply_req(3'b010, 3'b000, 32'h0000_0040);
    run_txn(3, {32{8'hA5}}, 3'b011, 3'b000, 32'h0000_0100);

    // Ports 0 and 1 both reading continuously
    run_txn(1, rand_line(), 3'b011, 3'b000, 32'h0000_0200);
    run_txn(0, rand_line(), 3'b011, 3'b000, 32'h0000_0300);
    run_txn(2, rand_line(), 3'b000, 3'b000, 32'h0);

    // Port0 illegal read+write, port1 write at 0x2000
    @(posedge clk); #1;
    apply_req(3'b001, 3'b011, 32'h0000_1000);
    run_txn(2, rand_line(), 3'b001, 3'b000, 32'h0000_0100);

    // Port0 read at 0x100; address moves to 0x200 while busy
    check("idle_before_grant", LW'(busy), LW'(1'b0));
    @(posedge clk); #1;
    port_address[0] = 32'h0000_0200;
    port_read = '0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_addr", LW'(pmem_address), LW'(32'h0000_0100));
    pmem_resp = 1'b1;
    exp_rsp_q.push_back({3'b001, pmem_rdata});
    @(posedge clk); #1;
    pmem_resp = 1'b0;

    // Reset two cycles into BUSY
    apply_req(3'b001, 3'b000, 32'h0000_0300);
    @(posedge clk); #1;
    check("mid_rst_granted", LW'(busy), LW'(1'b1));
    repeat (2) @(posedge clk);
    #1;
    port_read = '0;
    rst_n     = 1'b0;
    rr_start  = 0;
    #1;
    check("mid_rst_pmem_read", LW'(pmem_read), '0);
    check("mid_rst_busy", LW'(busy), '0);
    check("mid_rst_port_resp", LW'(port_resp), '0);
    check("mid_rst_address", LW'(pmem_address), '0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    pmem_resp = 1'b1;
    #1;
    check("late_resp_ignored", LW'(port_resp), '0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    check("late_resp_idle", LW'(busy), '0);

    // Randomized back-to-back traffic
    gen_set(rd, wr);
    apply_req(rd, wr, AW'($urandom()) & ~32'h3f);
    for (int k = 0; k < 60; k++) begin
      if (k == 59) begin
        nrd = '0;
        nwr = '0;
      end else begin
        gen_set(nrd, nwr);
      end
      run_txn($urandom_range(0, 4), rand_line(), nrd, nwr, AW'($urandom()) & ~32'h3f);
    end

    repeat (3) @(posedge clk);
    #1;
    check("req_q_empty", LW'(exp_req_q.size()), '0);
    check("rsp_q_empty", LW'(exp_rsp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
